hex_keypad_scanner: RTL
=======================

HEX_KEYPAD_SCANNER -- requirements
Module: hex_keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV_BITS, default 18, meaning a scan tick occurs every 2^SCAN_DIV_BITS clk cycles.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, meaning consecutive stable ticks needed to accept a press or a release (legal range 1..15).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port clr_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port row  input  4  keypad row sense, active-low, externally pulled up.
REQ-006 SHALL have port col  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port value  output  16  last four accepted key codes, newest in [3:0].
REQ-008 SHALL have port key_code  output  4  code of the most recently accepted key.
REQ-009 SHALL have port key_valid  output  1  one-clk pulse when a key press is accepted.
REQ-010 SHALL have port key_held  output  1  high while an accepted key is still held.

Function
REQ-011 SHALL run a free-running SCAN_DIV_BITS-bit divider; tick is asserted for one clk when the divider equals all-ones.
REQ-012 SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE; all state changes occur only on a tick, except the key_valid pulse timing in REQ-016.
REQ-013 SCAN: on each tick, sample row for the currently driven column; if row == 4'b1111, advance the column index by 1 (3 wraps to 0); otherwise capture column index c and row index r, do not advance, clear the debounce count, enter DEBOUNCE.
REQ-014 Several rows low simultaneously: the lowest-index low row SHALL be taken as r.
REQ-015 DEBOUNCE: on each tick, if row bit r is still low, increment the count; otherwise return to SCAN, advance the column, clear the count.
REQ-016 When the count reaches DEBOUNCE_SCANS: assert key_valid for exactly the clk following that tick, set key_code = {r[1:0], c[1:0]}, set value = {value[11:0], key_code_new}, set key_held = 1, enter HELD.
REQ-017 HELD: column stays fixed; on a tick with row bit r high, clear the count and enter RELEASE; otherwise remain in HELD.
REQ-018 RELEASE: on each tick with row bit r high, increment the count; a tick with row bit r low returns to HELD with no new key_valid.
REQ-019 When the RELEASE count reaches DEBOUNCE_SCANS: clear key_held, advance the column, enter SCAN.
REQ-020 A second key pressed while HELD or RELEASE SHALL be ignored (no key_valid, value unchanged).
REQ-021 col SHALL equal ~(4'b0001 << column index), registered, changing only on ticks.
REQ-022 row SHALL pass through a two-flop synchronizer before use; sampling uses the synchronized value.

Reset
REQ-023 While clr_n is low: divider = 0, state = SCAN, column index = 0 (col = 4'b1110), counts = 0, value = 16'h0000, key_code = 4'h0, key_valid = 0, key_held = 0, synchronizer flops = 4'b1111.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL abort without a key_valid pulse; after release, scanning restarts at column 0 from divider 0.

Verification (SCAN_DIV_BITS = 2, DEBOUNCE_SCANS = 3)
REQ-025 Idle: row = 4'b1111 after reset -> col cycles 1110, 1101, 1011, 0111, 1110 every 4 clk; key_valid never asserted.
REQ-026 Clean press row 2 / col 1, held 40 clk then released -> exactly one key_valid pulse, key_code = 4'h9, value = 16'h0009, key_held high until 3 release ticks, then scanning resumes from column 2.
REQ-027 Bounce: row 0 low on column 3 for 1 tick, high 1 tick, repeated 3 times -> no key_valid, value unchanged.
REQ-028 Sequence of presses 1, 2, 3, 4, 5 (codes 4'h1..4'h5), each cleanly pressed and released -> value = 16'h2345 after the fifth key_valid.
REQ-029 Rows 1 and 3 both low on column 0 -> key_code = 4'h4; extra key pressed during HELD -> no second pulse.
REQ-030 clr_n dropped for 1 clk during DEBOUNCE with 2 of 3 ticks counted -> all outputs per REQ-023, no key_valid, col = 4'b1110.

Source files
------------

// File: rtl/hex_keypad_scanner.sv
// Purpose: scans a 4x4 active-low keypad, debounces press and release, keeps the last four key codes.
// Latency: a key is accepted DEBOUNCE_SCANS scan ticks after first detection; key_valid pulses the clk after that tick.
// Backpressure: none; key_valid is a one-clk pulse and value/key_code hold until the next accepted key.
//
// Ports:
//   clk        system clock, rising edge
//   clr_n      asynchronous active-low reset
//   row[3:0]   keypad row sense, active-low (pulled up externally)
//   col[3:0]   keypad column drive, active-low, one-cold
//   value[15:0] last four accepted codes, newest in [3:0]
//   key_code   code {row, col} of the most recent accepted key
//   key_valid  one-clk pulse on acceptance
//   key_held   high while the accepted key is still down
module hex_keypad_scanner #(
    parameter int SCAN_DIV_BITS  = 18,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] value,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held
);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    // The counter holds the number of stable ticks seen minus one at the moment of
    // the decision, so the final tick is recognised when cnt equals this value.
    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS - 1);
    localparam logic [SCAN_DIV_BITS-1:0] DIV_ONE = {{(SCAN_DIV_BITS-1){1'b0}}, 1'b1};

    logic [SCAN_DIV_BITS-1:0] div;
    logic                     tick;
    logic [3:0]               row_s1;
    logic [3:0]               row_s2;
    state_t                   state;
    logic [1:0]               col_idx;
    logic [1:0]               row_idx;
    logic [3:0]               cnt;

    logic                     any_low;
    logic [1:0]               low_row;
    logic                     row_hit;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << idx;
        return ~one_hot;
    endfunction

    assign tick = &div;

    // Lowest-index low row wins when several rows are pulled low together.
    always_comb begin
        any_low = ~&row_s2;
        low_row = 2'd0;
        if (!row_s2[3]) low_row = 2'd3;
        if (!row_s2[2]) low_row = 2'd2;
        if (!row_s2[1]) low_row = 2'd1;
        if (!row_s2[0]) low_row = 2'd0;
    end

    // The captured key is still down when its row is low; the column is frozen
    // outside SCAN, so only the captured row needs watching.
    assign row_hit = ~row_s2[row_idx];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            div       <= '0;
            row_s1    <= 4'b1111;
            row_s2    <= 4'b1111;
            state     <= S_SCAN;
            col_idx   <= 2'd0;
            col       <= 4'b1110;
            row_idx   <= 2'd0;
            cnt       <= 4'd0;
            value     <= 16'h0000;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            div       <= div + DIV_ONE;
            row_s1    <= row;
            row_s2    <= row_s1;
            key_valid <= 1'b0;

            if (tick) begin
                case (state)
                    S_SCAN: begin
                        if (any_low) begin
                            row_idx <= low_row;
                            cnt     <= 4'd0;
                            state   <= S_DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            col     <= col_drive(col_idx + 2'd1);
                        end
                    end

                    S_DEBOUNCE: begin
                        if (row_hit) begin
                            if (cnt == DEB_LAST) begin
                                key_valid <= 1'b1;
                                key_code  <= {row_idx, col_idx};
                                value     <= {value[11:0], row_idx, col_idx};
                                key_held  <= 1'b1;
                                cnt       <= 4'd0;
                                state     <= S_HELD;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            cnt     <= 4'd0;
                            col_idx <= col_idx + 2'd1;
                            col     <= col_drive(col_idx + 2'd1);
                            state   <= S_SCAN;
                        end
                    end

                    S_HELD: begin
                        if (!row_hit) begin
                            cnt   <= 4'd0;
                            state <= S_RELEASE;
                        end
                    end

                    S_RELEASE: begin
                        if (!row_hit) begin
                            if (cnt == DEB_LAST) begin
                                key_held <= 1'b0;
                                cnt      <= 4'd0;
                                col_idx  <= col_idx + 2'd1;
                                col      <= col_drive(col_idx + 2'd1);
                                state    <= S_SCAN;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            // Release bounce: the key came back, no new press is reported.
                            cnt   <= 4'd0;
                            state <= S_HELD;
                        end
                    end

                    default: state <= S_SCAN;
                endcase
            end
        end
    end

endmodule
